// File: rtl/dac_pkg.sv
// dac_pkg: shared FSM encoding, frame constants and frame builder
// for the DAC8568-class serial write controller.
package dac_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam int          FRAME_LEN  = 32;
  localparam logic [3:0]  CMD_WR_UPD = 4'b0011;
  localparam logic [31:0] REF_FRAME  = 32'h0800_0001;

  function automatic logic [31:0] mk_frame(
    input logic [3:0]  addr,
    input logic [15:0] code
  );
    return {4'b0000, CMD_WR_UPD, addr, code, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_chan_arbiter.sv
// dac_chan_arbiter: round-robin first-pending search (combinational).
// Ports: i_pending, i_ptr in; o_sel (channel), o_any (any pending) out.
module dac_chan_arbiter #(
  parameter int N_CHAN = 8
) (
  input  logic [N_CHAN-1:0] i_pending,
  input  logic [3:0]        i_ptr,
  output logic [3:0]        o_sel,
  output logic              o_any
);

  logic [2*N_CHAN-1:0] w_dbl;
  logic [N_CHAN-1:0]   w_rot;
  logic [3:0]          w_off;
  logic [4:0]          w_sum;

  // rotate so the pointer channel sits at bit 0
  assign w_dbl = {i_pending, i_pending} >> i_ptr;
  assign w_rot = w_dbl[N_CHAN-1:0];

  // descending scan: lowest offset wins
  always_comb begin
    w_off = '0;
    for (int j = N_CHAN - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = 4'(j);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_sel = (w_sum >= 5'(N_CHAN)) ?
                 4'(w_sum - 5'(N_CHAN)) : w_sum[3:0];
  assign o_any = |i_pending;

endmodule

// File: rtl/dac_controller.sv
// dac_controller: buffers per-channel PID words, shifts 32-bit frames
// to the DAC. Ports: clk_in, n_reset_in, data_in, data_valid_in in;
// sync_n_out, sclk_out, din_out, busy_out, wr_done_out, wr_chan_out out.
module dac_controller
  import dac_pkg::*;
#(
  parameter int W_DATA  = 16,
  parameter int N_CHAN  = 8,
  parameter int MIN_GAP = 2,
  parameter int REF_EN  = 1
) (
  input  logic              clk_in,
  input  logic              n_reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [N_CHAN-1:0] data_valid_in,
  output logic              sync_n_out,
  output logic              sclk_out,
  output logic              din_out,
  output logic              busy_out,
  output logic              wr_done_out,
  output logic [3:0]        wr_chan_out
);

  state_t              r_state;
  logic [31:0]         r_shift;
  logic [7:0]          r_cnt;
  logic [N_CHAN-1:0]   r_pend;
  logic [W_DATA-1:0]   r_hold [N_CHAN];
  logic [3:0]          r_ptr;
  logic [3:0]          r_sel;
  logic                r_is_ref;
  logic                r_sync_n;
  logic                r_din;
  logic                r_done;
  logic [3:0]          r_wr_chan;

  logic [3:0]          w_sel;
  logic                w_any;
  logic [3:0]          w_nxt;
  logic [W_DATA-1:0]   w_word;
  logic [W_DATA-1:0]   w_ofs;
  logic [15:0]         w_code;
  logic [31:0]         w_frame;
  logic [N_CHAN-1:0]   w_clr;

  dac_chan_arbiter #(.N_CHAN(N_CHAN)) u_arb (
    .i_pending (r_pend),
    .i_ptr     (r_ptr),
    .o_sel     (w_sel),
    .o_any     (w_any)
  );

  // two's complement -> offset binary
  assign w_ofs = {~data_in[W_DATA-1], data_in[W_DATA-2:0]};

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (w_sel == 4'(i)) w_word = r_hold[i];
    end
  end

  // left-justify narrower words, zero fill below
  assign w_code  = 16'(w_word) << (16 - W_DATA);
  assign w_frame = mk_frame(w_sel, w_code);
  assign w_nxt   = (w_sel == 4'(N_CHAN - 1)) ? 4'd0 : w_sel + 4'd1;
  assign w_clr   = (r_state == ST_LOAD) ?
                   (N_CHAN'(1) << w_sel) : '0;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_state   <= (REF_EN != 0) ? ST_INIT : ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_is_ref  <= 1'b0;
      r_sync_n  <= 1'b1;
      r_din     <= 1'b0;
      r_done    <= 1'b0;
      r_wr_chan <= '0;
      for (int i = 0; i < N_CHAN; i++) r_hold[i] <= '0;
    end else begin
      r_done <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) begin
        if (data_valid_in[i]) r_hold[i] <= w_ofs;
      end
      // a write in the LOAD cycle re-arms the channel
      r_pend <= (r_pend & ~w_clr) | data_valid_in;
      unique case (r_state)
        ST_INIT: begin
          r_shift  <= REF_FRAME;
          r_din    <= REF_FRAME[31];
          r_sync_n <= 1'b0;
          r_is_ref <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_SHIFT;
        end
        ST_IDLE: begin
          if (w_any) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift  <= w_frame;
          r_din    <= w_frame[31];
          r_sync_n <= 1'b0;
          r_is_ref <= 1'b0;
          r_sel    <= w_sel;
          r_ptr    <= w_nxt;
          r_cnt    <= '0;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cnt == 8'(FRAME_LEN - 1)) begin
            r_sync_n <= 1'b1;
            r_din    <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_GAP;
            if (!r_is_ref) begin
              r_done    <= 1'b1;
              r_wr_chan <= r_sel;
            end
          end else begin
            r_shift <= r_shift << 1;
            r_din   <= r_shift[30];
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          // fold the idle decision into the last gap cycle
          if (r_cnt == 8'(MIN_GAP - 1)) begin
            r_cnt   <= '0;
            r_state <= w_any ? ST_LOAD : ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // generic equivalent of the DDR forward (D0=1, D1=0, set=sync_n)
  assign sclk_out    = r_sync_n | clk_in;
  assign sync_n_out  = r_sync_n;
  assign din_out     = r_din;
  assign wr_done_out = r_done;
  assign wr_chan_out = r_wr_chan;
  assign busy_out    = (r_state != ST_IDLE) || (|r_pend);

endmodule
